// File: rtl/dsi_payload_crc.sv
// DSI long-packet payload CRC-16 generator/checker (poly 0x1021 reflected 0x8408, seed 0xFFFF, LSB-first, no final XOR).
// Latency: crc/crc_valid/crc_err/sop_err/busy update 1 cycle after an accepted beat (PIPE=0), 2 cycles (PIPE=1).
// Backpressure: none; one beat per cycle whenever en is high, en=0 holds all state.
//
// Ports:
//   clk, reset        : single clock, synchronous active-high reset
//   en, sop, last     : beat valid and packet framing (framing qualified by en)
//   last_cnt          : valid bytes in the final beat minus 1 (clamped to NBYTES)
//   data              : NBYTES payload bytes, byte 0 in data[7:0] is sent first
//   chk_en, rx_crc    : optional compare against the received CRC, sampled with the last beat
//   crc               : running/final CRC register
//   crc_valid,crc_err : one-cycle pulses at end of packet
//   sop_err           : one-cycle pulse when sop restarts an open packet
//   busy              : packet open
module dsi_payload_crc #(
    parameter int NBYTES = 8,
    parameter int PIPE   = 0,
    localparam int CW    = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  sop,
    input  logic                  last,
    input  logic [CW-1:0]         last_cnt,
    input  logic [8*NBYTES-1:0]   data,
    input  logic                  chk_en,
    input  logic [15:0]           rx_crc,
    output logic [15:0]           crc,
    output logic                  crc_valid,
    output logic                  crc_err,
    output logic                  sop_err,
    output logic                  busy
);

    localparam logic [CW:0] NMAX = (CW+1)'(NBYTES);

    // Number of bytes to fold this beat: full beat unless last, then last_cnt+1 clamped to NBYTES.
    logic [CW:0] n_in;
    always_comb begin
        n_in = (CW+1)'(last_cnt) + (CW+1)'(1);
        if (!last || (n_in > NMAX))
            n_in = NMAX;
    end

    // Beat as seen by the CRC register, either straight from the ports or one stage later.
    logic                  p_en;
    logic                  p_sop;
    logic                  p_last;
    logic                  p_chk;
    logic [CW:0]           p_n;
    logic [8*NBYTES-1:0]   p_data;
    logic [15:0]           p_rx;

    generate
        if (PIPE != 0) begin : g_pipe
            always_ff @(posedge clk) begin
                if (reset) begin
                    p_en   <= 1'b0;
                    p_sop  <= 1'b0;
                    p_last <= 1'b0;
                    p_chk  <= 1'b0;
                    p_n    <= '0;
                    p_data <= '0;
                    p_rx   <= '0;
                end else begin
                    p_en   <= en;
                    p_sop  <= sop;
                    p_last <= last;
                    p_chk  <= chk_en;
                    p_n    <= n_in;
                    p_data <= data;
                    p_rx   <= rx_crc;
                end
            end
        end else begin : g_direct
            assign p_en   = en;
            assign p_sop  = sop;
            assign p_last = last;
            assign p_chk  = chk_en;
            assign p_n    = n_in;
            assign p_data = data;
            assign p_rx   = rx_crc;
        end
    endgenerate

    // Serial bitwise fold of the first n bytes; bytes at and above n are ignored.
    function automatic logic [15:0] fold_bytes(input logic [15:0] start,
                                               input logic [8*NBYTES-1:0] d,
                                               input logic [CW:0] n);
        logic [15:0] c;
        c = start;
        for (int k = 0; k < NBYTES; k++) begin
            if (k < int'(n)) begin
                for (int b = 0; b < 8; b++) begin
                    if (c[0] ^ d[8*k+b])
                        c = (c >> 1) ^ 16'h8408;
                    else
                        c = c >> 1;
                end
            end
        end
        return c;
    endfunction

    logic [15:0] crc_next;
    always_comb begin
        crc_next = fold_bytes(p_sop ? 16'hFFFF : crc, p_data, p_n);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc       <= 16'hFFFF;
            crc_valid <= 1'b0;
            crc_err   <= 1'b0;
            sop_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            crc_err   <= 1'b0;
            sop_err   <= 1'b0;
            if (p_en) begin
                crc <= crc_next;
                // sop on an open packet abandons it and restarts from the seed.
                if (p_sop && busy)
                    sop_err <= 1'b1;
                if (p_last) begin
                    crc_valid <= 1'b1;
                    crc_err   <= p_chk && (crc_next != p_rx);
                    busy      <= 1'b0;
                end else if (p_sop) begin
                    busy      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dsi_payload_crc.sv
// Directed bench for dsi_payload_crc: three instances (8 bytes/no pipe, 16 bytes/pipe, 1 byte/no pipe).
// Expected CRCs are fixed constants for the reference DSI payload vectors.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dsi_payload_crc;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // NBYTES=8, PIPE=0
    logic        en8 = 0, sop8 = 0, last8 = 0, chk8 = 0;
    logic [2:0]  lc8 = 0;
    logic [63:0] d8 = 0;
    logic [15:0] rx8 = 0;
    logic [15:0] crc8;
    logic        val8, err8, serr8, busy8;

    // NBYTES=16, PIPE=1
    logic         en16 = 0, sop16 = 0, last16 = 0, chk16 = 0;
    logic [3:0]   lc16 = 0;
    logic [127:0] d16 = 0;
    logic [15:0]  rx16 = 0;
    logic [15:0]  crc16;
    logic         val16, err16, serr16, busy16;

    // NBYTES=1, PIPE=0
    logic        en1 = 0, sop1 = 0, last1 = 0, chk1 = 0;
    logic [0:0]  lc1 = 0;
    logic [7:0]  d1 = 0;
    logic [15:0] rx1 = 0;
    logic [15:0] crc1;
    logic        val1, err1, serr1, busy1;

    dsi_payload_crc #(.NBYTES(8), .PIPE(0)) u8 (
        .clk(clk), .reset(reset), .en(en8), .sop(sop8), .last(last8), .last_cnt(lc8),
        .data(d8), .chk_en(chk8), .rx_crc(rx8), .crc(crc8), .crc_valid(val8),
        .crc_err(err8), .sop_err(serr8), .busy(busy8));

    dsi_payload_crc #(.NBYTES(16), .PIPE(1)) u16 (
        .clk(clk), .reset(reset), .en(en16), .sop(sop16), .last(last16), .last_cnt(lc16),
        .data(d16), .chk_en(chk16), .rx_crc(rx16), .crc(crc16), .crc_valid(val16),
        .crc_err(err16), .sop_err(serr16), .busy(busy16));

    dsi_payload_crc #(.NBYTES(1), .PIPE(0)) u1 (
        .clk(clk), .reset(reset), .en(en1), .sop(sop1), .last(last1), .last_cnt(lc1),
        .data(d1), .chk_en(chk1), .rx_crc(rx1), .crc(crc1), .crc_valid(val1),
        .crc_err(err1), .sop_err(serr1), .busy(busy1));

    logic [7:0] vb [2][24];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic beat8(input int v, input int off, input logic s, input logic l,
                         input logic ck, input logic [15:0] rx);
        for (int k = 0; k < 8; k++)
            d8[8*k +: 8] = vb[v][off+k];
        en8 = 1'b1; sop8 = s; last8 = l; lc8 = 3'd7; chk8 = ck; rx8 = rx;
        @(negedge clk);
        en8 = 1'b0; sop8 = 1'b0; last8 = 1'b0; chk8 = 1'b0;
    endtask

    task automatic pkt8(input int v, input logic ck, input logic [15:0] rx);
        beat8(v, 0, 1'b1, 1'b0, 1'b0, 16'h0);
        beat8(v, 8, 1'b0, 1'b0, 1'b0, 16'h0);
        beat8(v, 16, 1'b0, 1'b1, ck, rx);
    endtask

    task automatic beat1(input logic [7:0] b, input logic s, input logic l, input logic [0:0] lc);
        d1 = b; en1 = 1'b1; sop1 = s; last1 = l; lc1 = lc;
        @(negedge clk);
        en1 = 1'b0; sop1 = 1'b0; last1 = 1'b0;
    endtask

    initial begin
        vb[0] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h1E, 8'hF0, 8'h1E, 8'hC7,
                  8'h4F, 8'h82, 8'h78, 8'hC5, 8'h82, 8'hE0, 8'h8C, 8'h70,
                  8'hD2, 8'h3C, 8'h78, 8'hE9, 8'hFF, 8'h00, 8'h00, 8'h01};
        vb[1] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                  8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                  8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

        // Reset state
        reset = 1'b1;
        idle(2);
        check("rst_crc", crc8, 16'hFFFF);
        check("rst_valid", 16'(val8), 16'h0);
        check("rst_err", 16'(err8), 16'h0);
        check("rst_sop_err", 16'(serr8), 16'h0);
        check("rst_busy", 16'(busy8), 16'h0);
        check("rst_crc16", crc16, 16'hFFFF);
        reset = 1'b0;
        idle(1);

        // Vector 1 then vector 2 back-to-back on the 8-byte instance
        beat8(0, 0, 1'b1, 1'b0, 1'b0, 16'h0);
        check("v1_busy_up", 16'(busy8), 16'h1);
        check("v1_no_valid_b0", 16'(val8), 16'h0);
        beat8(0, 8, 1'b0, 1'b0, 1'b0, 16'h0);
        beat8(0, 16, 1'b0, 1'b1, 1'b0, 16'h0);
        check("v1_crc", crc8, 16'hE569);
        check("v1_valid", 16'(val8), 16'h1);
        check("v1_busy_down", 16'(busy8), 16'h0);
        beat8(1, 0, 1'b1, 1'b0, 1'b0, 16'h0);
        check("v2_valid_pulse_end", 16'(val8), 16'h0);
        check("v2_busy_up", 16'(busy8), 16'h1);
        beat8(1, 8, 1'b0, 1'b0, 1'b0, 16'h0);
        beat8(1, 16, 1'b0, 1'b1, 1'b0, 16'h0);
        check("v2_crc", crc8, 16'h00F0);
        check("v2_valid", 16'(val8), 16'h1);
        idle(1);
        check("v2_hold_crc", crc8, 16'h00F0);
        check("v2_hold_valid", 16'(val8), 16'h0);

        // Check mode: matching then mismatching received CRC
        pkt8(0, 1'b1, 16'hE569);
        check("chk_ok_valid", 16'(val8), 16'h1);
        check("chk_ok_err", 16'(err8), 16'h0);
        idle(1);
        pkt8(0, 1'b1, 16'hE568);
        check("chk_bad_valid", 16'(val8), 16'h1);
        check("chk_bad_err", 16'(err8), 16'h1);
        idle(1);
        check("chk_bad_err_pulse", 16'(err8), 16'h0);

        // Abort/restart: sop on beat 2 of an open packet
        beat8(1, 0, 1'b1, 1'b0, 1'b0, 16'h0);
        beat8(0, 0, 1'b1, 1'b0, 1'b0, 16'h0);
        check("abort_sop_err", 16'(serr8), 16'h1);
        check("abort_no_valid", 16'(val8), 16'h0);
        check("abort_busy", 16'(busy8), 16'h1);
        beat8(0, 8, 1'b0, 1'b0, 1'b0, 16'h0);
        check("abort_sop_err_pulse", 16'(serr8), 16'h0);
        check("abort_no_valid2", 16'(val8), 16'h0);
        beat8(0, 16, 1'b0, 1'b1, 1'b0, 16'h0);
        check("abort_crc", crc8, 16'hE569);
        check("abort_valid", 16'(val8), 16'h1);
        idle(1);

        // Reset mid-packet after 2 beats
        beat8(0, 0, 1'b1, 1'b0, 1'b0, 16'h0);
        beat8(0, 8, 1'b0, 1'b0, 1'b0, 16'h0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("midrst_crc", crc8, 16'hFFFF);
        check("midrst_busy", 16'(busy8), 16'h0);
        check("midrst_valid", 16'(val8), 16'h0);
        idle(1);
        check("midrst_valid2", 16'(val8), 16'h0);
        pkt8(0, 1'b0, 16'h0);
        check("midrst_v1_crc", crc8, 16'hE569);
        check("midrst_v1_valid", 16'(val8), 16'h1);
        idle(1);

        // 16-byte pipelined instance: full beat plus 8-byte partial beat with junk above
        for (int k = 0; k < 16; k++)
            d16[8*k +: 8] = vb[0][k];
        en16 = 1'b1; sop16 = 1'b1; last16 = 1'b0; lc16 = 4'd0;
        @(negedge clk);
        check("p16_busy_delayed", 16'(busy16), 16'h0);
        for (int k = 0; k < 8; k++)
            d16[8*k +: 8] = vb[0][16+k];
        for (int k = 8; k < 16; k++)
            d16[8*k +: 8] = 8'hA5 ^ 8'(k);
        sop16 = 1'b0; last16 = 1'b1; lc16 = 4'd7;
        @(negedge clk);
        en16 = 1'b0; last16 = 1'b0;
        check("p16_busy_up", 16'(busy16), 16'h1);
        check("p16_valid_early", 16'(val16), 16'h0);
        idle(1);
        check("p16_crc", crc16, 16'hE569);
        check("p16_valid", 16'(val16), 16'h1);
        check("p16_busy_down", 16'(busy16), 16'h0);
        idle(1);
        check("p16_valid_pulse", 16'(val16), 16'h0);

        // 1-byte instance: 24 single-byte beats with random gaps
        for (int i = 0; i < 24; i++) begin
            idle($urandom_range(0, 2));
            beat1(vb[0][i], i == 0, i == 23, 1'b0);
        end
        check("b1_crc", crc1, 16'hE569);
        check("b1_valid", 16'(val1), 16'h1);
        idle(1);

        // Single-beat packet, one zero byte from the seed: busy must not rise
        beat1(8'h00, 1'b1, 1'b1, 1'b0);
        check("single_crc", crc1, 16'h0F87);
        check("single_valid", 16'(val1), 16'h1);
        check("single_busy", 16'(busy1), 16'h0);
        idle(1);
        check("single_busy_after", 16'(busy1), 16'h0);

        // last_cnt beyond NBYTES clamps to one byte
        beat1(8'h00, 1'b1, 1'b1, 1'b1);
        check("clamp_crc", crc1, 16'h0F87);
        check("clamp_valid", 16'(val1), 16'h1);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
